bp_ct_credit_return: RTL
========================

BP_CT_CREDIT_RETURN -- requirements
Module: bp_ct_credit_return

Interface
REQ-001 The block SHALL have parameter ct_remote_credits_p, default 32: receive-buffer depth advertised to the remote transmitter (power of two, at least 2^ct_lg_credit_decimation_p).
REQ-002 The block SHALL have parameter ct_lg_credit_decimation_p, default 3: log2 of credits batched per return token (D = 2^ct_lg_credit_decimation_p).
REQ-003 The block SHALL have parameter flush_timeout_p, default 64: idle cycles before a partial flush; used only with the flush macro.
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock; all state rises on it.
REQ-005 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port recv_v_i, input, 1 bit: one flit landed in the local buffer, consuming one remote credit.
REQ-007 The block SHALL have port free_v_i, input, 1 bit: the local consumer released one buffer slot.
REQ-008 The block SHALL have port credit_v_o, output, 1 bit: a credit-return token is valid.
REQ-009 The block SHALL have port credit_count_o, output, clog2(ct_remote_credits_p+1) bits: number of credits the token returns.
REQ-010 The block SHALL have port credit_ready_i, input, 1 bit: the return link accepts the token.
REQ-011 The block SHALL have port pending_o, output, clog2(ct_remote_credits_p+1) bits: credits freed but not yet returned.
REQ-012 The block SHALL have port error_o, output, 1 bit: sticky protocol-violation flag.

Function
REQ-013 The block SHALL keep an occupancy counter that adds recv_v_i and subtracts free_v_i each cycle; simultaneous recv and free leave it unchanged.
REQ-014 The block SHALL set error_o when recv_v_i would push occupancy above ct_remote_credits_p (overflow), or when free_v_i arrives with occupancy 0 (underflow); in either case the counter holds its value and error_o stays set until reset.
REQ-015 The block SHALL keep a pending counter that adds 1 per accepted free_v_i and subtracts the launched count when a token launches; a free in the same cycle as a launch nets both.
REQ-016 The block SHALL implement a state machine with two states: e_idle (credit_v_o=0) and e_send (credit_v_o=1).
REQ-017 In e_idle, when pending >= D, the block SHALL launch on the next edge: move to e_send, register credit_count_o = D, and subtract D from pending. Latency from the free that reaches threshold to credit_v_o=1 is 1 cycle.
REQ-018 In e_send, the block SHALL hold credit_count_o stable while credit_ready_i is 0.
REQ-019 In e_send, on credit_v_o & credit_ready_i, the block SHALL relaunch back-to-back (stay in e_send with a new D) if post-update pending >= D, and otherwise return to e_idle.
REQ-020 Pending SHALL never exceed ct_remote_credits_p; the counters SHALL never wrap.
REQ-021 credit_count_o SHALL read 0 whenever credit_v_o is 0.

Reset
REQ-022 Asserting reset_i, including mid-handshake, SHALL immediately force: state e_idle, credit_v_o=0, credit_count_o=0, pending_o=0, occupancy=0, error_o=0, and idle timer=0.
REQ-023 A token that was outstanding when reset was asserted SHALL be dropped, not replayed.

Configuration
REQ-024 With BP_CT_CREDIT_FLUSH_EN defined, the block SHALL include an idle timer that increments each cycle the block is in e_idle with 0 < pending < D and no free_v_i, and clears otherwise. When the timer reaches flush_timeout_p, the block SHALL launch a token with count = pending, zero pending, and clear the timer.
REQ-025 Without BP_CT_CREDIT_FLUSH_EN, the block SHALL have no timer and every token SHALL carry exactly D; partial credits wait indefinitely. flush_timeout_p is then unused.

Verification
REQ-026 Scenario: reset, then 8 recv followed by 8 free on consecutive cycles, credit_ready_i=1 -> one token, count 8, the cycle after the 8th free; pending_o returns to 0.
REQ-027 Scenario: 16 frees with credit_ready_i=0 for 5 cycles, then 1 -> count 8 held for 5 cycles, then two back-to-back tokens of 8; pending_o never exceeds 16.
REQ-028 Scenario: 33 recv with no free -> error_o=1 on the 33rd and stays set; a free with occupancy 0 after reset -> error_o=1.
REQ-029 Scenario: with BP_CT_CREDIT_FLUSH_EN, 3 frees then idle -> token with count 3 after 64 idle cycles. Without the macro, the same stimulus -> no token, pending_o=3.
REQ-030 Scenario: reset_i asserted while credit_v_o=1 and not ready -> credit_v_o=0 in the same cycle, with no relaunch after release.

Source files
------------

// File: rtl/bp_ct_credit_return.sv
// bp_ct_credit_return
// Batches locally freed receive-buffer slots into credit-return tokens of
// D = 2^ct_lg_credit_decimation_p credits each. It tracks buffer occupancy
// and flags protocol violations (overflow/underflow) with a sticky error bit.
// Optional feature macro: BP_CT_CREDIT_FLUSH_EN -- adds an idle timer that
// flushes a partial batch (fewer than D credits) after flush_timeout_p idle
// cycles.
module bp_ct_credit_return #(
    parameter int ct_remote_credits_p       = 32,
    parameter int ct_lg_credit_decimation_p = 3,
    parameter int flush_timeout_p           = 64
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     recv_v_i,
    input  logic                                     free_v_i,
    output logic                                     credit_v_o,
    output logic [$clog2(ct_remote_credits_p+1)-1:0] credit_count_o,
    input  logic                                     credit_ready_i,
    output logic [$clog2(ct_remote_credits_p+1)-1:0] pending_o,
    output logic                                     error_o
);

    localparam int           W       = $clog2(ct_remote_credits_p + 1);
    localparam logic [W-1:0] MAX_CNT = W'(ct_remote_credits_p);
    localparam logic [W-1:0] D_CNT   = W'(1 << ct_lg_credit_decimation_p);
    localparam logic [W-1:0] ONE     = W'(1);

    typedef enum logic {
        e_idle = 1'b0,
        e_send = 1'b1
    } state_e;

    state_e       state_r, state_n;
    logic [W-1:0] occ_r, occ_n;
    logic [W-1:0] pend_r, pend_n;
    logic [W-1:0] cnt_r, cnt_n;
    logic         err_r, err_n;
    logic [W-1:0] pend_sum;
    logic         overflow, underflow, free_ok, handshake;

`ifdef BP_CT_CREDIT_FLUSH_EN
    localparam int            TW         = $clog2(flush_timeout_p + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(flush_timeout_p - 1);
    localparam logic [TW-1:0] TONE       = TW'(1);

    logic [TW-1:0] timer_r, timer_n;
    logic          idle_tick;
`else
    logic unused_flush_timeout;
    assign unused_flush_timeout = (flush_timeout_p > 0);
`endif

    // Saturating increment: pending must never wrap, even if the remote
    // misbehaves and refills the buffer faster than credits are returned.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic inc);
        if (inc && (v < MAX_CNT)) begin
            return v + ONE;
        end
        return v;
    endfunction

    // Next-state logic: occupancy tracking, error detection, pending
    // accumulation and the idle/send token FSM.
    always_comb begin
        state_n   = state_r;
        occ_n     = occ_r;
        cnt_n     = cnt_r;
        err_n     = err_r;

        // A recv with a simultaneous free nets to zero and cannot overflow;
        // likewise a free with a simultaneous recv cannot underflow.
        overflow  = recv_v_i && !free_v_i && (occ_r == MAX_CNT);
        underflow = free_v_i && !recv_v_i && (occ_r == '0);
        free_ok   = free_v_i && !underflow;

        if (recv_v_i && !free_v_i && !overflow) begin
            occ_n = occ_r + ONE;
        end else if (free_v_i && !recv_v_i && !underflow) begin
            occ_n = occ_r - ONE;
        end
        err_n = err_r || overflow || underflow;

        pend_sum  = sat_inc(pend_r, free_ok);
        pend_n    = pend_sum;
        handshake = (state_r == e_send) && credit_ready_i;

        // Launch (or relaunch back-to-back) whenever the post-update pending
        // reaches a full batch; otherwise a retired token drops to idle.
        if ((state_r == e_idle) || handshake) begin
            if (pend_sum >= D_CNT) begin
                state_n = e_send;
                cnt_n   = D_CNT;
                pend_n  = pend_sum - D_CNT;
            end else begin
                state_n = e_idle;
                cnt_n   = '0;
            end
        end

`ifdef BP_CT_CREDIT_FLUSH_EN
        idle_tick = (state_r == e_idle) && (pend_r != '0) && (pend_r < D_CNT) && !free_v_i;
        timer_n   = idle_tick ? (timer_r + TONE) : '0;
        if (idle_tick && (timer_r == TIMER_LAST)) begin
            state_n = e_send;
            cnt_n   = pend_r;
            pend_n  = '0;
            timer_n = '0;
        end
`endif
    end

    // State registers; reset drops any outstanding token without replay.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            occ_r   <= '0;
            pend_r  <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
`ifdef BP_CT_CREDIT_FLUSH_EN
            timer_r <= '0;
`endif
        end else begin
            state_r <= state_n;
            occ_r   <= occ_n;
            pend_r  <= pend_n;
            cnt_r   <= cnt_n;
            err_r   <= err_n;
`ifdef BP_CT_CREDIT_FLUSH_EN
            timer_r <= timer_n;
`endif
        end
    end

    assign credit_v_o     = (state_r == e_send);
    assign credit_count_o = cnt_r;
    assign pending_o      = pend_r;
    assign error_o        = err_r;

endmodule
